// File: rtl/d2_uop_sequencer_pkg.sv
// Shared constants for the D2 micro-op sequencer and its index counter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package d2_uop_sequencer_pkg;

  // Default width of the uop index: up to 2**UOP_W_DEF uops per instruction.
  localparam int UOP_W_DEF = 3;

  // D2 occupancy state. The state bit doubles as the D2 valid flag.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_BUSY  = 1'b1;

  // Index of the first uop of every instruction.
  localparam logic [UOP_W_DEF-1:0] UOP_IDX_ZERO = '0;

endpackage

// File: rtl/d2_uop_counter.sv
// Micro-op index register with clear/increment and an at-or-past-last compare.
// Latency: idx updates on the clock edge after clr/inc; at_last is combinational on idx/last_idx.
// Backpressure: none of its own; the caller withholds inc to hold the index.
//
// Ports:
//   clk, rst_n   stage clock, asynchronous active-low clear
//   clr          synchronous clear to uop 0 (has priority over inc)
//   inc          advance to the next uop
//   last_idx     index of the final uop of the current instruction
//   idx          current uop index
//   at_last      idx >= last_idx
module d2_uop_counter
  import d2_uop_sequencer_pkg::*;
#(
  parameter int UOP_W = UOP_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [UOP_W-1:0] last_idx,
  output logic [UOP_W-1:0] idx,
  output logic             at_last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= UOP_W'(UOP_IDX_ZERO);
    end else if (clr) begin
      idx <= UOP_W'(UOP_IDX_ZERO);
    end else if (inc) begin
      idx <= idx + UOP_W'(1);
    end
  end

  // >= rather than == so a last_idx that drops below the current index
  // mid-instruction still terminates the instruction instead of wrapping.
  assign at_last = (idx >= last_idx);

endmodule

// File: rtl/d2_uop_sequencer.sv
// Decode-two sequencer: tracks D2 occupancy and steps the uop index, issuing one uop per cycle to AG.
// Latency: an instruction latched at edge N is presented to AG in cycle N+1; k uops take k unstalled cycles.
// Backpressure: AG_STALL/DEP_STALL hold the current uop; D1_STALL holds decode-one while uops remain.
//
// Ports:
//   CLK, RST          stage clock, asynchronous active-low reset
//   D1_V              decode-one offers an instruction
//   CS_UOP_LAST_IDX   final uop index of the D2 instruction (0 = single uop)
//   AG_STALL          AG cannot take a uop this cycle
//   DEP_STALL         operand dependency blocks the current uop
//   FLUSH             squash D2 contents
//   LD_D2_LATCH       load enable for the external D2 IR/EIP/CS latch
//   D1_STALL          hold decode-one outputs
//   D2_V_AG           uop presented to AG is valid
//   UOP_IDX           index of the presented uop
//   UOP_FIRST         presented uop is uop 0
//   UOP_LAST          presented uop is the final one
//   EIP_ADV           final uop issued; EIP may advance
module d2_uop_sequencer
  import d2_uop_sequencer_pkg::*;
#(
  parameter int UOP_W = UOP_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             D1_V,
  input  logic [UOP_W-1:0] CS_UOP_LAST_IDX,
  input  logic             AG_STALL,
  input  logic             DEP_STALL,
  input  logic             FLUSH,
  output logic             LD_D2_LATCH,
  output logic             D1_STALL,
  output logic             D2_V_AG,
  output logic [UOP_W-1:0] UOP_IDX,
  output logic             UOP_FIRST,
  output logic             UOP_LAST,
  output logic             EIP_ADV
);

  logic [0:0]       state_q;
  logic [0:0]       state_d;
  logic             v;
  logic [UOP_W-1:0] idx;
  logic             at_last;
  logic             last;
  logic             issue;
  logic             retire;
  logic             idx_clr;
  logic             idx_inc;

  assign v      = (state_q == ST_BUSY);
  assign last   = v & at_last;
  assign issue  = v & ~AG_STALL & ~DEP_STALL & ~FLUSH;
  assign retire = issue & last;

  // Any cycle that opens D2 to a new instruction also restarts the index.
  assign idx_clr = FLUSH | ~v | retire;
  assign idx_inc = issue & ~last;

  d2_uop_counter #(
    .UOP_W (UOP_W)
  ) u_counter (
    .clk      (CLK),
    .rst_n    (RST),
    .clr      (idx_clr),
    .inc      (idx_inc),
    .last_idx (CS_UOP_LAST_IDX),
    .idx      (idx),
    .at_last  (at_last)
  );

  always_comb begin
    state_d = state_q;
    if (FLUSH) begin
      state_d = ST_EMPTY;
    end else if (!v || retire) begin
      // Zero-bubble handoff: a retiring instruction is replaced in the same edge.
      state_d = D1_V ? ST_BUSY : ST_EMPTY;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // AG_STALL deliberately leaves D2_V_AG high: AG takes the uop once it drops.
  assign D2_V_AG   = v & ~FLUSH & ~DEP_STALL;
  assign UOP_IDX   = idx;
  assign UOP_FIRST = v & (idx == UOP_W'(UOP_IDX_ZERO));
  assign UOP_LAST  = last;
  assign EIP_ADV   = retire;

  // Both latch control outputs are forced low while reset is held.
  assign LD_D2_LATCH = RST & idx_clr;
  assign D1_STALL    = RST & ~LD_D2_LATCH;

endmodule

// File: doc/d2_uop_sequencer.md
Name: d2_uop_sequencer

Overview:
Sequencer for the decode-two stage. It tracks whether D2 holds a valid instruction and steps a micro-op index through multi-uop instructions such as CMPXCHG, far control transfers and push/pop forms. It issues one uop per cycle to AG and controls loading of the D2 input latch. It stalls decode-one while an instruction still has uops left, and it obeys AG back-pressure, dependency stalls and pipeline flush.

Parameters:
UOP_W, 3, width of uop index; up to 2**UOP_W uops per instruction

Ports:
CLK  in  1  stage clock
RST  in  1  asynchronous active-low reset
D1_V  in  1  decode-one presents a valid instruction this cycle
CS_UOP_LAST_IDX  in  UOP_W  index of final uop of the instruction currently in D2, from the control store; 0 means single-uop
AG_STALL  in  1  AG cannot accept a uop this cycle
DEP_STALL  in  1  operand dependency; the current uop must not issue
FLUSH  in  1  synchronous squash of D2 contents, from branch resolution
LD_D2_LATCH  out  1  enable for the external D2 IR/EIP/CS latch
D1_STALL  out  1  hold decode-one outputs
D2_V_AG  out  1  uop presented to AG is valid
UOP_IDX  out  UOP_W  index of uop being presented
UOP_FIRST  out  1  UOP_IDX == 0
UOP_LAST  out  1  current uop is the final one
EIP_ADV  out  1  pulse when the final uop issues; EIP may advance by INST_LENGTH

Behaviour:
- State: V (D2 holds an instruction) and IDX (UOP_W bits). Two states: EMPTY (V=0) and BUSY (V=1).
- Reset: RST low clears V=0 and IDX=0 immediately, without a clock edge.
  - While RST is low, every output is 0, including LD_D2_LATCH and D1_STALL.
- Combinational terms:
  - last = V & (IDX >= CS_UOP_LAST_IDX). The >= comparison guarantees termination if LAST_IDX changes mid-instruction.
  - issue = V & ~AG_STALL & ~DEP_STALL & ~FLUSH.
- Outputs:
  - D2_V_AG = V & ~FLUSH & ~DEP_STALL.
  - D2_V_AG stays asserted under AG_STALL; AG samples the uop on the cycle AG_STALL is low.
  - UOP_IDX = IDX.
  - UOP_FIRST = V & (IDX==0).
  - UOP_LAST = last.
  - EIP_ADV = issue & last.
  - LD_D2_LATCH = RST & (FLUSH | ~V | (issue & last)).
  - D1_STALL = RST & ~LD_D2_LATCH.
- Next state, in priority order:
  1. FLUSH: V<=0, IDX<=0. D1_V is ignored that cycle; the latch load is a don't-care because V=0.
  2. EMPTY (V=0): V<=D1_V, IDX<=0.
  3. BUSY, issue & last: V<=D1_V, IDX<=0. Back-to-back instructions are taken with zero bubble.
  4. BUSY, issue & ~last: IDX<=IDX+1, V holds.
  5. BUSY, no issue (AG_STALL or DEP_STALL): V and IDX hold.
- Latency: a single-uop instruction latched at edge N is presented to AG in cycle N+1. An instruction with k uops occupies D2 for k unstalled cycles.
- Wrap: IDX never increments past CS_UOP_LAST_IDX. With LAST_IDX = 2**UOP_W-1, IDX reaches its maximum, then clears to 0; it never wraps by overflow.
- Simultaneous events:
  - FLUSH together with AG_STALL: flush wins.
  - FLUSH on the final-uop cycle: no EIP_ADV.
  - DEP_STALL with AG_STALL: hold.
- Reset mid-instruction discards the remaining uops. After RST rises, the block is EMPTY and accepts the next D1_V.

Decomposition:
- Shared package holds:
  - UOP_W default.
  - State encoding: EMPTY=1'b0, BUSY=1'b1.
  - Constant UOP_IDX_ZERO.
- One sub-module, d2_uop_counter: UOP_W-bit register with async active-low clear, synchronous clear and increment enable, and a >= compare against LAST_IDX. The top level holds the V flop and the output/next-state logic.

Test Plan:
1. Single-uop stream: RST released, D1_V=1 every cycle, LAST_IDX=0 -> from cycle 1, D2_V_AG=1, UOP_FIRST=UOP_LAST=1, EIP_ADV=1 and LD_D2_LATCH=1 every cycle; D1_STALL stays 0.
2. 3-uop instruction: LAST_IDX=2, no stalls -> UOP_IDX 0,1,2 on consecutive cycles; D1_STALL=1 for the first two cycles; UOP_LAST and EIP_ADV only at IDX=2; next instruction presented the following cycle with IDX=0.
3. AG_STALL high for 2 cycles at IDX=1 of a LAST_IDX=3 instruction -> IDX holds at 1 and D2_V_AG stays 1; the sequence then continues 2,3 with a single EIP_ADV.
4. FLUSH at IDX=1 of a LAST_IDX=2 instruction, D1_V=1 -> that cycle D2_V_AG=0 and EIP_ADV=0; next cycle V=0, IDX=0 and D2_V_AG=0; the cycle after that reloads from D1.
5. RST pulsed low mid-edge at IDX=2 of a LAST_IDX=4 instruction -> all outputs 0 before the next clock edge; after release, the first D1_V is accepted with IDX=0.
6. LAST_IDX changed from 5 to 1 while IDX=3 -> last=1 immediately, EIP_ADV pulses once on issue, and IDX returns to 0.
